cnn_stage_sequencer: RTL and testbench

Frame-level controller for the layered CNN pipeline (conv/pool/buffer stages followed by the fully-connected stage). It issues one-cycle `start` pulses to each stage, collects each stage's `ready` (done) pulse, and hands a frame to the next stage only when that stage is free. Each stage therefore holds at most one frame. A progress watchdog detects hung stages. The block sits beside the datapath in the top level on the 200 MHz domain and replaces hard-wired `ready`→`start` chaining.

---
 rtl/cnn_stage_sequencer_if.sv | 30 +++
 rtl/cnn_stage_sequencer.sv | 132 +++++++++++++
 tb/tb_cnn_stage_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stage_sequencer_if.sv
// Handshake bundle between the frame sequencer and the CNN pipeline stages.
// The slave side is the sequencer; the master side drives frame requests and
// stage completion pulses and observes starts, busy bits and status.
interface cnn_stage_sequencer_if #(
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 16
);
    logic                frame_req;
    logic [N_STAGES-1:0] stage_done;
    logic                clear_err;
    logic [N_STAGES-1:0] stage_start;
    logic [N_STAGES-1:0] stage_busy;
    logic                frame_ack;
    logic                frame_done;
    logic [CNT_W-1:0]    frame_count;
    logic                timeout_err;
    logic                spurious_err;

    modport master (
        output frame_req, stage_done, clear_err,
        input  stage_start, stage_busy, frame_ack, frame_done,
               frame_count, timeout_err, spurious_err
    );

    modport slave (
        input  frame_req, stage_done, clear_err,
        output stage_start, stage_busy, frame_ack, frame_done,
               frame_count, timeout_err, spurious_err
    );
endinterface

// File: rtl/cnn_stage_sequencer.sv
// Frame-level controller for the layered CNN pipeline. Each stage owns at most
// one frame; a finished frame waits in its stage (pend) until the next stage is
// free. All decisions look only at registered state, so a stage freed on one
// edge is restarted on the following edge at the earliest. A progress watchdog
// drops everything into ERROR when a stage hangs.
module cnn_stage_sequencer #(
    parameter int N_STAGES = 4,
    parameter int TIMEOUT  = 65535,
    parameter int CNT_W    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    cnn_stage_sequencer_if.slave    bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERROR
    } state_t;

    state_t              state;
    logic [N_STAGES-1:0] busy;
    logic [N_STAGES-2:0] pend;
    logic [WD_W-1:0]     wdog;
    logic [N_STAGES-1:0] start_q;
    logic                ack_q;
    logic                frame_done_q;
    logic [CNT_W-1:0]    count_q;
    logic                timeout_q;
    logic                spurious_q;

    logic [N_STAGES-1:0] done_acc;
    logic [N_STAGES-1:0] done_bad;
    logic [N_STAGES-2:0] handoff;
    logic [N_STAGES-1:0] start_nx;
    logic [N_STAGES-1:0] clr_busy;
    logic [N_STAGES-1:0] busy_nx;
    logic [N_STAGES-2:0] pend_nx;
    logic                launch;
    logic                progress;
    logic                wd_fire;

    // Per-stage launch/handoff/completion decisions, all stages in parallel.
    always_comb begin
        done_acc = bus.stage_done & busy;
        done_bad = bus.stage_done & ~busy;
        launch   = bus.frame_req & ~busy[0];
        handoff  = '0;
        for (int i = 0; i < N_STAGES - 1; i++) begin
            handoff[i] = (pend[i] | done_acc[i]) & ~busy[i+1];
        end
        start_nx = {handoff, launch};
        clr_busy = {done_acc[N_STAGES-1], handoff};
        busy_nx  = (busy | start_nx) & ~clr_busy;
        pend_nx  = (pend | done_acc[N_STAGES-2:0]) & ~handoff;
        progress = (|start_nx) | (|done_acc);
        wd_fire  = !progress && (|busy) && (wdog == WD_W'(TIMEOUT - 1));
    end

    // Sequencer FSM: stage ownership, registered outputs, sticky flags, watchdog.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= '0;
            pend         <= '0;
            wdog         <= '0;
            start_q      <= '0;
            ack_q        <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= '0;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            case (state)
                ERROR: begin
                    busy         <= '0;
                    pend         <= '0;
                    wdog         <= '0;
                    start_q      <= '0;
                    ack_q        <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (bus.clear_err) begin
                        state      <= IDLE;
                        timeout_q  <= 1'b0;
                        spurious_q <= 1'b0;
                    end
                end
                default: begin
                    spurious_q <= (spurious_q & ~bus.clear_err) | (|done_bad);
                    if (wd_fire) begin
                        state        <= ERROR;
                        timeout_q    <= 1'b1;
                        busy         <= '0;
                        pend         <= '0;
                        wdog         <= '0;
                        start_q      <= '0;
                        ack_q        <= 1'b0;
                        frame_done_q <= 1'b0;
                    end else begin
                        state        <= ((|busy_nx) || bus.frame_req) ? RUN : IDLE;
                        timeout_q    <= timeout_q & ~bus.clear_err;
                        busy         <= busy_nx;
                        pend         <= pend_nx;
                        start_q      <= start_nx;
                        ack_q        <= launch;
                        frame_done_q <= done_acc[N_STAGES-1];
                        if (done_acc[N_STAGES-1]) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (bus.clear_err || progress || !(|busy)) begin
                            wdog <= '0;
                        end else begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.stage_start  = start_q;
    assign bus.stage_busy   = busy;
    assign bus.frame_ack    = ack_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.frame_count  = count_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.spurious_err = spurious_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer: a small stage responder plus a scoreboard of
// expected start/frame_done cycles, covering single frames, backpressure,
// same-edge completions, spurious dones, the watchdog, counter wrap and reset.
module tb_cnn_stage_sequencer;

    localparam int N  = 4;
    localparam int TO = 20;
    localparam int CW = 4;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    always #5 clk_in = ~clk_in;

    cnn_stage_sequencer_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

    cnn_stage_sequencer #(.N_STAGES(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int tests_run        = 0;
    int tests_failed     = 0;
    int cyc              = 0;
    int frames_requested = 0;
    int ack_count        = 0;
    int exp_count        = 0;
    int ack_base         = 0;
    int lat [N];
    int due [N];
    int exp_start [N][$];
    int exp_done [$];

    task automatic checkOutput(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sampleOutputs();
        for (int i = 0; i < N; i++) begin
            if (bus.stage_start[i]) begin
                if (exp_start[i].size() > 0)
                    checkOutput($sformatf("start%0d_cycle", i), cyc, exp_start[i].pop_front());
                else
                    checkOutput($sformatf("start%0d_unexpected", i), cyc, -1);
                if (lat[i] > 0) due[i] = cyc + lat[i];
            end
        end
        if (bus.stage_start[0]) checkOutput("ack_with_start0", int'(bus.frame_ack), 1);
        if (bus.frame_ack) ack_count++;
        if (bus.frame_done) begin
            if (exp_done.size() > 0)
                checkOutput("frame_done_cycle", cyc, exp_done.pop_front());
            else
                checkOutput("frame_done_unexpected", cyc, -1);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample at the falling edge.
    task automatic applyStimulus(input logic [N-1:0] done_mask, input logic clr);
        logic [N-1:0] auto_done;
        @(posedge clk_in);
        #1;
        cyc++;
        auto_done = '0;
        for (int i = 0; i < N; i++) begin
            if (due[i] == cyc) begin
                auto_done[i] = 1'b1;
                due[i] = -1;
            end
        end
        bus.frame_req  = (frames_requested > ack_count);
        bus.stage_done = done_mask | auto_done;
        bus.clear_err  = clr;
        @(negedge clk_in);
        sampleOutputs();
    endtask

    task automatic step(input int n);
        repeat (n) applyStimulus('0, 1'b0);
    endtask

    task automatic setLat(input int l);
        for (int i = 0; i < N; i++) lat[i] = l;
    endtask

    task automatic expectDrained(input string tag);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("%s_sb_start%0d_left", tag, i), exp_start[i].size(), 0);
        checkOutput($sformatf("%s_sb_done_left", tag), exp_done.size(), 0);
        checkOutput($sformatf("%s_busy", tag), int'(bus.stage_busy), 0);
        checkOutput($sformatf("%s_count", tag), int'(bus.frame_count), exp_count % (1 << CW));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) due[i] = -1;
        frames_requested = ack_count;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic runFrame(input int l);
        int b;
        setLat(l);
        frames_requested++;
        applyStimulus('0, 1'b0);
        b = cyc;
        for (int i = 0; i < N; i++) exp_start[i].push_back(b + 1 + i * (l + 1));
        exp_done.push_back(b + 1 + N * (l + 1));
        exp_count++;
        step(N * (l + 1) + 1);
    endtask

    initial begin
        int b, r, c, d, e, f, g, h, k, w;
        setLat(-1);
        for (int i = 0; i < N; i++) due[i] = -1;
        bus.frame_req  = 1'b0;
        bus.stage_done = '0;
        bus.clear_err  = 1'b0;

        // Reset state
        step(2);
        checkOutput("rst_busy", int'(bus.stage_busy), 0);
        checkOutput("rst_start", int'(bus.stage_start), 0);
        checkOutput("rst_ack", int'(bus.frame_ack), 0);
        checkOutput("rst_frame_done", int'(bus.frame_done), 0);
        checkOutput("rst_count", int'(bus.frame_count), 0);
        checkOutput("rst_timeout", int'(bus.timeout_err), 0);
        checkOutput("rst_spurious", int'(bus.spurious_err), 0);
        rst_n = 1'b1;
        step(2);

        // Single frame, 10 cycles per stage
        runFrame(10);
        expectDrained("single");

        // Backpressure: stage 3 held, five frames streamed
        for (int i = 0; i < N; i++) lat[i] = (i == N - 1) ? -1 : 2;
        ack_base = ack_count;
        frames_requested += 5;
        applyStimulus('0, 1'b0);
        b = cyc;
        exp_start[0].push_back(b + 1);  exp_start[0].push_back(b + 5);
        exp_start[0].push_back(b + 9);  exp_start[0].push_back(b + 13);
        exp_start[1].push_back(b + 4);  exp_start[1].push_back(b + 8);
        exp_start[1].push_back(b + 12);
        exp_start[2].push_back(b + 7);  exp_start[2].push_back(b + 11);
        exp_start[3].push_back(b + 10);
        step(20);
        checkOutput("bp_busy_full", int'(bus.stage_busy), 15);
        checkOutput("bp_pend_full", int'(dut.pend), 7);
        checkOutput("bp_acks_stalled", ack_count - ack_base, 4);
        lat[N-1] = 2;
        applyStimulus(4'b1000, 1'b0);
        r = cyc;
        for (int j = 0; j < 5; j++) exp_done.push_back(r + 1 + 4 * j);
        exp_count += 5;
        exp_start[3].push_back(r + 2);  exp_start[3].push_back(r + 6);
        exp_start[3].push_back(r + 10); exp_start[3].push_back(r + 14);
        exp_start[2].push_back(r + 3);  exp_start[2].push_back(r + 7);
        exp_start[2].push_back(r + 11);
        exp_start[1].push_back(r + 4);  exp_start[1].push_back(r + 8);
        exp_start[0].push_back(r + 5);
        step(19);
        checkOutput("bp_acks_total", ack_count - ack_base, 5);
        expectDrained("backpressure");

        // Same-edge done on stages 1 and 2 with stage 3 idle
        setLat(-1);
        frames_requested += 2;
        applyStimulus('0, 1'b0);
        c = cyc;
        exp_start[0].push_back(c + 1);
        step(2);
        applyStimulus(4'b0001, 1'b0);
        c = cyc;
        exp_start[1].push_back(c + 1);
        exp_start[0].push_back(c + 2);
        step(2);
        applyStimulus(4'b0010, 1'b0);
        d = cyc;
        exp_start[2].push_back(d + 1);
        step(1);
        applyStimulus(4'b0001, 1'b0);
        e = cyc;
        exp_start[1].push_back(e + 1);
        step(2);
        applyStimulus(4'b0110, 1'b0);
        f = cyc;
        exp_start[3].push_back(f + 1);
        exp_start[2].push_back(f + 2);
        step(1);
        checkOutput("simul_pend1_waiting", int'(dut.pend[1]), 1);
        step(2);
        applyStimulus(4'b1000, 1'b0);
        g = cyc;
        exp_done.push_back(g + 1);
        exp_count++;
        step(1);
        applyStimulus(4'b0100, 1'b0);
        h = cyc;
        exp_start[3].push_back(h + 1);
        step(2);
        applyStimulus(4'b1000, 1'b0);
        exp_done.push_back(cyc + 1);
        exp_count++;
        step(3);
        expectDrained("simul");

        // Spurious done while idle
        checkOutput("spur_before", int'(bus.spurious_err), 0);
        applyStimulus(4'b0100, 1'b0);
        step(1);
        checkOutput("spur_set", int'(bus.spurious_err), 1);
        checkOutput("spur_busy", int'(bus.stage_busy), 0);
        checkOutput("spur_count", int'(bus.frame_count), exp_count % (1 << CW));
        applyStimulus('0, 1'b1);
        step(1);
        checkOutput("spur_cleared", int'(bus.spurious_err), 0);

        // Watchdog: stage 0 never completes
        setLat(-1);
        frames_requested++;
        applyStimulus('0, 1'b0);
        w = cyc;
        exp_start[0].push_back(w + 1);
        step(20);
        checkOutput("wd_not_yet", int'(bus.timeout_err), 0);
        checkOutput("wd_busy_hung", int'(bus.stage_busy), 1);
        step(1);
        checkOutput("wd_fired", int'(bus.timeout_err), 1);
        checkOutput("wd_busy_cleared", int'(bus.stage_busy), 0);
        frames_requested++;
        step(6);
        checkOutput("wd_req_not_acked", frames_requested - ack_count, 1);
        checkOutput("wd_sticky", int'(bus.timeout_err), 1);
        setLat(2);
        applyStimulus('0, 1'b1);
        k = cyc;
        exp_start[0].push_back(k + 2);
        exp_start[1].push_back(k + 5);
        exp_start[2].push_back(k + 8);
        exp_start[3].push_back(k + 11);
        exp_done.push_back(k + 14);
        exp_count++;
        step(1);
        checkOutput("wd_cleared", int'(bus.timeout_err), 0);
        step(15);
        expectDrained("watchdog");

        // Counter wrap: 17 frames from reset
        doReset();
        exp_count = 0;
        for (int n = 1; n <= 17; n++) begin
            runFrame(1);
            if (n == 16) checkOutput("wrap_16", int'(bus.frame_count), 0);
        end
        checkOutput("wrap_17", int'(bus.frame_count), 1);
        expectDrained("wrap");

        // Asynchronous reset mid-frame
        setLat(5);
        frames_requested++;
        applyStimulus('0, 1'b0);
        b = cyc;
        exp_start[0].push_back(b + 1);
        exp_start[1].push_back(b + 7);
        step(8);
        checkOutput("midrst_busy_before", int'(bus.stage_busy), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(bus.stage_busy), 0);
        checkOutput("midrst_count", int'(bus.frame_count), 0);
        checkOutput("midrst_start", int'(bus.stage_start), 0);
        checkOutput("midrst_timeout", int'(bus.timeout_err), 0);
        for (int i = 0; i < N; i++) due[i] = -1;
        exp_count = 0;
        step(2);
        rst_n = 1'b1;
        step(3);
        checkOutput("midrst_spurious", int'(bus.spurious_err), 0);
        expectDrained("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
